uart_cfg: RTL

//  Runtime-configurable UART: programmable baud divisor, data width, parity and stop bits,

---
 rtl/uart_cfg.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART with 16x oversampling.
//   Baud divisor, parity mode and stop-bit count are sampled per frame (TX at accept,
//   RX at start detect). TX is a single holding register with valid/ready handshake;
//   RX words land in a show-ahead FIFO together with their parity/framing flags.
// Ports:
//   clk, reset                  reference clock, synchronous active-high reset
//   baud_div                    sample tick every baud_div+1 clk
//   par_mode, two_stop          0/3=no parity, 1=even, 2=odd; two_stop selects 2 stop bits
//   rin / rout                  serial line in (async) / out
//   tx_data, tx_valid, tx_ready TX word handshake; tx_done pulses at end of last stop bit
//   rx_data, rx_perr, rx_ferr   FIFO head word and its flags
//   rx_valid, rx_ready          FIFO head handshake (pop on valid&ready)
//   rx_overrun                  pulse when a completed frame is dropped on a full FIFO
//   rx_busy                     frame reception in progress
module uart_cfg #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned DivWidth = 16,
  parameter int unsigned OvsLog2  = 4,
  parameter int unsigned FifoAw   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DivWidth-1:0] baud_div,
  input  logic [1:0]          par_mode,
  input  logic                two_stop,
  input  logic                rin,
  output logic                rout,
  input  logic [DataBits-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_done,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_perr,
  output logic                rx_ferr,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overrun,
  output logic                rx_busy
);

  localparam int unsigned        BitCntW   = $clog2(DataBits);
  localparam logic [BitCntW-1:0] LastBit   = BitCntW'(DataBits - 1);
  localparam logic [OvsLog2-1:0] OvsLast   = '1;
  localparam logic [OvsLog2-1:0] OvsHalfM1 = OvsLast >> 1;
  localparam int unsigned        Depth     = 2 ** FifoAw;
  localparam logic [FifoAw:0]    FullCnt   = {1'b1, {FifoAw{1'b0}}};
  localparam int unsigned        WordW     = DataBits + 2;

  function automatic logic parity_of(input logic [DataBits-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------------------
  // Baud tick. The limit is reloaded only at wrap so a divisor change never
  // produces a truncated or stretched tick period mid-count.
  // ---------------------------------------------------------------------------
  logic [DivWidth-1:0] div_cnt_q, div_lim_q;
  logic                tick;

  assign tick = (div_cnt_q == div_lim_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      div_lim_q <= baud_div;
    end else if (tick) begin
      div_cnt_q <= '0;
      div_lim_q <= baud_div;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {TxIdle, TxArm, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e           tx_state_q;
  logic [DataBits-1:0] tx_shift_q;
  logic                tx_par_en_q, tx_par_bit_q, tx_two_q;
  logic [OvsLog2-1:0]  tx_ovs_q;
  logic [BitCntW-1:0]  tx_bit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= TxIdle;
      tx_shift_q   <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_two_q     <= 1'b0;
      tx_ovs_q     <= '0;
      tx_bit_q     <= '0;
      rout         <= 1'b1;
      tx_ready     <= 1'b1;
      tx_done      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_valid && tx_ready) begin
            tx_shift_q   <= tx_data;
            tx_par_en_q  <= (par_mode == 2'd1) || (par_mode == 2'd2);
            tx_par_bit_q <= parity_of(tx_data, par_mode == 2'd2);
            tx_two_q     <= two_stop;
            tx_ready     <= 1'b0;
            tx_state_q   <= TxArm;
          end
        end
        // Hold off until the next tick so the start bit is a full bit period.
        TxArm: begin
          if (tick) begin
            rout       <= 1'b0;
            tx_ovs_q   <= '0;
            tx_state_q <= TxStart;
          end
        end
        default: begin
          if (tick) begin
            tx_ovs_q <= tx_ovs_q + 1'b1;
            if (tx_ovs_q == OvsLast) begin
              unique case (tx_state_q)
                TxStart: begin
                  rout       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_bit_q   <= '0;
                  tx_state_q <= TxData;
                end
                TxData: begin
                  if (tx_bit_q == LastBit) begin
                    tx_bit_q <= '0;
                    if (tx_par_en_q) begin
                      rout       <= tx_par_bit_q;
                      tx_state_q <= TxParity;
                    end else begin
                      rout       <= 1'b1;
                      tx_state_q <= TxStop;
                    end
                  end else begin
                    rout       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= tx_bit_q + 1'b1;
                  end
                end
                TxParity: begin
                  rout       <= 1'b1;
                  tx_bit_q   <= '0;
                  tx_state_q <= TxStop;
                end
                TxStop: begin
                  if (tx_two_q && (tx_bit_q == '0)) begin
                    tx_bit_q <= tx_bit_q + 1'b1;
                  end else begin
                    tx_done    <= 1'b1;
                    tx_ready   <= 1'b1;
                    tx_state_q <= TxIdle;
                  end
                end
                default: tx_state_q <= TxIdle;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;

  logic                rin_meta_q, rin_s_q;
  rx_state_e           rx_state_q;
  logic [DataBits-1:0] rx_shift_q;
  logic                rx_par_en_q, rx_par_odd_q, rx_two_q;
  logic                rx_perr_q, rx_ferr_q;
  logic [OvsLog2-1:0]  rx_ovs_q;
  logic [BitCntW-1:0]  rx_bit_q;
  logic                push_q;
  logic [WordW-1:0]    push_word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rin_meta_q <= 1'b1;
      rin_s_q    <= 1'b1;
    end else begin
      rin_meta_q <= rin;
      rin_s_q    <= rin_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= RxIdle;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_two_q     <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_ovs_q     <= '0;
      rx_bit_q     <= '0;
      rx_busy      <= 1'b0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (tick && !rin_s_q) begin
            rx_par_en_q  <= (par_mode == 2'd1) || (par_mode == 2'd2);
            rx_par_odd_q <= (par_mode == 2'd2);
            rx_two_q     <= two_stop;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_ovs_q     <= '0;
            rx_bit_q     <= '0;
            rx_busy      <= 1'b1;
            rx_state_q   <= RxStart;
          end
        end
        // Line held low after a framing error: a low level here is not a start bit.
        RxWaitHigh: begin
          if (rin_s_q) rx_state_q <= RxIdle;
        end
        // Mid start bit re-check rejects short glitches; afterwards every
        // OvsLast+1 ticks lands on the middle of the next bit.
        RxStart: begin
          if (tick) begin
            if (rx_ovs_q == OvsHalfM1) begin
              rx_ovs_q <= '0;
              if (rin_s_q) begin
                rx_busy    <= 1'b0;
                rx_state_q <= RxIdle;
              end else begin
                rx_state_q <= RxData;
              end
            end else begin
              rx_ovs_q <= rx_ovs_q + 1'b1;
            end
          end
        end
        default: begin
          if (tick) begin
            rx_ovs_q <= rx_ovs_q + 1'b1;
            if (rx_ovs_q == OvsLast) begin
              unique case (rx_state_q)
                RxData: begin
                  rx_shift_q <= {rin_s_q, rx_shift_q[DataBits-1:1]};
                  if (rx_bit_q == LastBit) begin
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_par_en_q ? RxParity : RxStop;
                  end else begin
                    rx_bit_q <= rx_bit_q + 1'b1;
                  end
                end
                RxParity: begin
                  rx_perr_q  <= rin_s_q != parity_of(rx_shift_q, rx_par_odd_q);
                  rx_state_q <= RxStop;
                end
                RxStop: begin
                  if (rx_two_q && (rx_bit_q == '0)) begin
                    rx_ferr_q <= rx_ferr_q | ~rin_s_q;
                    rx_bit_q  <= rx_bit_q + 1'b1;
                  end else begin
                    push_q      <= 1'b1;
                    push_word_q <= {rx_perr_q, rx_ferr_q | ~rin_s_q, rx_shift_q};
                    rx_busy     <= 1'b0;
                    rx_state_q  <= rin_s_q ? RxIdle : RxWaitHigh;
                  end
                end
                default: rx_state_q <= RxIdle;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (show-ahead). A pop frees the slot a same-cycle push needs when full.
  // ---------------------------------------------------------------------------
  logic [WordW-1:0]  mem [Depth];
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [FifoAw:0]   count_q;
  logic              full, pop, do_push;

  assign rx_valid = (count_q != '0);
  assign full     = (count_q == FullCnt);
  assign pop      = rx_valid && rx_ready;
  assign do_push  = push_q && (!full || pop);
  assign {rx_perr, rx_ferr, rx_data} = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push_q && full && !pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule
